bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Sequencer for multi-digit BCD addition. It reuses one single-digit BCD add stage serially, one digit per clock, LSD first.
- Accepts two packed DIGITS-wide BCD operands through a start/ready handshake.
- Validates every digit up front, then produces a (DIGITS+1)-digit BCD sum with a one-cycle done pulse.
- Sits between a command source (keypad/UART decode) and display/result registers.

Parameters:
- DIGITS, 4, number of BCD digits per operand (legal range 2..16).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- b  input  4*DIGITS  operand B, same packing as a.
- ready  output  1  high only in IDLE; start accepted on an edge where start&ready.
- busy  output  1  high in CHECK and RUN.
- done  output  1  one-cycle pulse; sum/invalid valid from this cycle.
- sum  output  4*(DIGITS+1)  BCD result; top digit is 0 or 1 (final carry).
- invalid  output  1  set when any input digit > 9; held until next accepted start.

Behaviour:
- Clock/reset (already decided): one clock; reset is asynchronous and active-high.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, digit index=0, carry=0, sum=0, invalid=0, done=0.
  - ready=1 combinationally while in IDLE.
  - No partial result survives.
- Operand capture: on the accepting edge, a and b are latched into internal registers. Later changes on a/b have no effect on the operation in flight.
- FSM states: IDLE, CHECK, RUN, DONE.
  - IDLE: ready=1. On start=1, latch operands, clear sum and carry, invalid=0, go to CHECK.
  - CHECK (one cycle): examine all latched digits. If any digit of A or B > 9: invalid=1, sum=0, go to DONE. Else go to RUN with idx=0.
  - RUN (exactly DIGITS cycles), at each edge:
    - s5 = A[idx] + B[idx] + carry (5-bit; max 19).
    - If s5 > 9: digit = (s5+6)[3:0], carry=1. Else digit = s5[3:0], carry=0.
    - Write digit into sum[4*idx +: 4]; idx++.
    - On the edge processing idx=DIGITS-1: write carry-out into sum[4*DIGITS +: 4] (value 0001 or 0000) and go to DONE.
  - DONE (one cycle): done=1. Next edge goes to IDLE.
- start is ignored outside IDLE (no queueing). start held high continuously gives back-to-back operations, one every DIGITS+3 cycles.
- Latency, counting the accepting edge as E0:
  - Valid operands: done high in the cycle after edge E(DIGITS+1); ready returns after E(DIGITS+2).
  - Invalid operands: done high after E1; ready returns after E2.
- sum and invalid hold their values after DONE until the next accepted start clears them (sum is cleared on the accepting edge).
- sum lower digits update progressively during RUN and may be read only when done=1.
- Width rule: the digit adder is 5 bits internally. No truncation before the >9 compare.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, CHECK, RUN, DONE}.
  - Constants BCD_MAX=4'd9, BCD_ADJ=4'd6.
  - Function is_bcd(digit).
- Sub-module bcd_digit_add: combinational a[3:0], b[3:0], cin → s[3:0], cout. Instantiated once, driven by the idx-selected latched digits.
- Controller holds the FSM, idx counter ($clog2(DIGITS) bits), carry flop, operand registers and sum register.

Test Plan (DIGITS=4):
- A=0x1234, B=0x5678, pulse start → after DIGITS+2 edges done=1, sum=0x06912, invalid=0; ready=1 the following cycle.
- A=0x9999, B=0x0001 → sum=0x10000 (carry ripples through all 4 digits), invalid=0.
- A=0x9999, B=0x9999 → sum=0x19998; also A=0x0000, B=0x0000 → sum=0x00000.
- A=0x12A4, B=0x0001 → done one cycle after CHECK (2 edges after accept), invalid=1, sum=0. Repeat with the bad digit only in B (B=0xF000) → same response.
- Start accepted for 0x1234+0x5678; change a/b and pulse start during RUN → start ignored, result still 0x06912. Next start accepted in IDLE adds 0x0005+0x0005 → sum=0x00010, invalid cleared.
- Assert rst for 1 cycle during the 2nd RUN cycle → sum=0, invalid=0, done=0, ready=1 immediately. A following 0x0001+0x0001 gives sum=0x00002 with normal latency.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Also provides the digit validity check.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   function automatic logic is_bcd(input logic [3:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: a + b + cin with decimal adjust.
// The raw sum is kept at 5 bits so the >9 compare sees the true value.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] s5_s;

   // raw binary sum, widened before adding
   always_comb begin
      s5_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   end

   // decimal adjust when the raw sum leaves the BCD range
   always_comb begin
      s    = s5_s[3:0];
      cout = 1'b0;
      if (s5_s > {1'b0, BCD_MAX}) begin
         s    = s5_s[3:0] + BCD_ADJ;
         cout = 1'b1;
      end else begin
         s    = s5_s[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD addition sequencer: validates latched operands, then adds
// one digit per clock (LSD first) through a single shared digit adder.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [4*DIGITS-1:0]       a,
   input  logic [4*DIGITS-1:0]       b,
   output logic                      ready,
   output logic                      busy,
   output logic                      done,
   output logic [4*(DIGITS+1)-1:0]   sum,
   output logic                      invalid
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   state_t                 state_r;
   logic [IW-1:0]          idx_r;
   logic                   carry_r;
   logic [4*DIGITS-1:0]    a_r;
   logic [4*DIGITS-1:0]    b_r;

   logic                   operands_ok_s;
   logic [3:0]             dig_a_s;
   logic [3:0]             dig_b_s;
   logic [3:0]             dig_s;
   logic                   cout_s;

   // every latched digit of both operands must be 0..9
   always_comb begin
      operands_ok_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         operands_ok_s = operands_ok_s & is_bcd(a_r[4*i +: 4]) & is_bcd(b_r[4*i +: 4]);
      end
   end

   assign dig_a_s = a_r[4*idx_r +: 4];
   assign dig_b_s = b_r[4*idx_r +: 4];

   bcd_digit_add u_digit_add (
      .a    (dig_a_s),
      .b    (dig_b_s),
      .cin  (carry_r),
      .s    (dig_s),
      .cout (cout_s)
   );

   assign ready = (state_r == IDLE);
   assign busy  = (state_r == CHECK) || (state_r == RUN);

   // sequencer: capture, validate, per-digit add, one-cycle done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= IDX_ZERO;
         carry_r <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         sum     <= '0;
         invalid <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  sum     <= '0;
                  carry_r <= 1'b0;
                  invalid <= 1'b0;
                  idx_r   <= IDX_ZERO;
                  state_r <= CHECK;
               end else begin
                  state_r <= IDLE;
               end
            end
            CHECK: begin
               if (operands_ok_s) begin
                  idx_r   <= IDX_ZERO;
                  state_r <= RUN;
               end else begin
                  invalid <= 1'b1;
                  sum     <= '0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end
            end
            RUN: begin
               sum[4*idx_r +: 4] <= dig_s;
               carry_r           <= cout_s;
               if (idx_r == IDX_LAST) begin
                  sum[4*DIGITS +: 4] <= {3'b000, cout_s};
                  idx_r              <= IDX_ZERO;
                  done               <= 1'b1;
                  state_r            <= DONE;
               end else begin
                  idx_r   <= idx_r + IDX_ONE;
                  state_r <= RUN;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl with DIGITS=4.
module tb_bcd_serial_add_ctrl;

   localparam int DIGITS = 4;

   logic                    clk;
   logic                    rst;
   logic                    start;
   logic [4*DIGITS-1:0]     a;
   logic [4*DIGITS-1:0]     b;
   logic                    ready;
   logic                    busy;
   logic                    done;
   logic [4*(DIGITS+1)-1:0] sum;
   logic                    invalid;

   int tests;
   int fails;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .invalid (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive one start pulse; returns at the negedge after the accepting edge
   task automatic do_accept(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts edges from the next one until done is seen; -1 on timeout
   task automatic wait_done(output int k);
      bit seen;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 50) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) k = -1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 16'h0000;
      b     = 16'h0000;
      #12;
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (sum !== 20'h00000) begin fails++; $display("FAIL reset_sum got %h want 00000", sum); end
      tests++; if (invalid !== 1'b0) begin fails++; $display("FAIL reset_invalid got %b want 0", invalid); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add(input logic [15:0] av, input logic [15:0] bv, input logic [19:0] exp_sum,
                           input string name);
      int k;
      do_accept(av, bv);
      tests++; if (busy !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL %s_busy got busy=%b ready=%b want 1/0", name, busy, ready); end
      wait_done(k);
      tests++; if (k != DIGITS + 1) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, k, DIGITS + 1); end
      tests++; if (sum !== exp_sum) begin fails++; $display("FAIL %s_sum got %h want %h", name, sum, exp_sum); end
      tests++; if (invalid !== 1'b0) begin fails++; $display("FAIL %s_invalid got %b want 0", name, invalid); end
      @(posedge clk);
      @(negedge clk);
      tests++; if (ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL %s_after got ready=%b done=%b want 1/0", name, ready, done); end
      tests++; if (sum !== exp_sum) begin fails++; $display("FAIL %s_hold got %h want %h", name, sum, exp_sum); end
   endtask

   task automatic test_invalid(input logic [15:0] av, input logic [15:0] bv, input string name);
      int k;
      do_accept(av, bv);
      wait_done(k);
      tests++; if (k != 1) begin fails++; $display("FAIL %s_latency got %0d want 1", name, k); end
      tests++; if (invalid !== 1'b1) begin fails++; $display("FAIL %s_invalid got %b want 1", name, invalid); end
      tests++; if (sum !== 20'h00000) begin fails++; $display("FAIL %s_sum got %h want 00000", name, sum); end
      @(posedge clk);
      @(negedge clk);
      tests++; if (ready !== 1'b1 || invalid !== 1'b1) begin fails++; $display("FAIL %s_after got ready=%b invalid=%b want 1/1", name, ready, invalid); end
   endtask

   task automatic test_start_ignored();
      int k;
      do_accept(16'h1234, 16'h5678);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      a     = 16'h0005;
      b     = 16'h0005;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(k);
      tests++; if (k != 2) begin fails++; $display("FAIL ignore_latency got %0d want 2", k); end
      tests++; if (sum !== 20'h06912) begin fails++; $display("FAIL ignore_sum got %h want 06912", sum); end
      @(posedge clk);
      @(negedge clk);
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ignore_ready got %b want 1", ready); end
   endtask

   task automatic test_mid_run_reset();
      do_accept(16'h1234, 16'h5678);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      tests++; if (sum[3:0] !== 4'h2 || busy !== 1'b1) begin fails++; $display("FAIL midrun_progress got digit0=%h busy=%b want 2/1", sum[3:0], busy); end
      rst = 1'b1;
      #1;
      tests++; if (sum !== 20'h00000) begin fails++; $display("FAIL midrun_rst_sum got %h want 00000", sum); end
      tests++; if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrun_rst_ready got ready=%b busy=%b want 1/0", ready, busy); end
      tests++; if (done !== 1'b0 || invalid !== 1'b0) begin fails++; $display("FAIL midrun_rst_flags got done=%b invalid=%b want 0/0", done, invalid); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      int first;
      int second;
      int k;
      first  = -1;
      second = -1;
      @(negedge clk);
      a     = 16'h1111;
      b     = 16'h2222;
      start = 1'b1;
      @(posedge clk);
      k = 0;
      while (second < 0 && k < 40) begin
         @(negedge clk);
         if (done) begin
            if (first < 0) first = k;
            else second = k;
         end
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      start = 1'b0;
      tests++; if (first != DIGITS + 1) begin fails++; $display("FAIL b2b_first got %0d want %0d", first, DIGITS + 1); end
      tests++; if (second - first != DIGITS + 3) begin fails++; $display("FAIL b2b_period got %0d want %0d", second - first, DIGITS + 3); end
      tests++; if (sum !== 20'h03333) begin fails++; $display("FAIL b2b_sum got %h want 03333", sum); end
      @(posedge clk);
      @(negedge clk);
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b want 1", ready); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_add(16'h1234, 16'h5678, 20'h06912, "basic");
      test_add(16'h9999, 16'h0001, 20'h10000, "ripple");
      test_add(16'h9999, 16'h9999, 20'h19998, "max");
      test_add(16'h0000, 16'h0000, 20'h00000, "zero");
      test_invalid(16'h12A4, 16'h0001, "bad_a");
      test_invalid(16'h0001, 16'hF000, "bad_b");
      test_start_ignored();
      test_add(16'h0005, 16'h0005, 20'h00010, "after_ignore");
      test_mid_run_reset();
      test_add(16'h0001, 16'h0001, 20'h00002, "after_reset");
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
